// File: rtl/sep_pkg.sv
// rtl/sep_pkg.sv - shared mode encodings and helpers for the two-band separator
package sep_pkg;

    typedef enum logic [1:0] {
        SEP_MODE_SEPARATE = 2'b00,
        SEP_MODE_LOWBYP   = 2'b01,
        SEP_MODE_HIGHONLY = 2'b10,
        SEP_MODE_RSVD     = 2'b11
    } sep_mode_e;

    function automatic int midscale(input int w);
        return 1 << (w - 1);
    endfunction

    // Clamp a signed value into the unsigned range of a w-bit word.
    function automatic int sat_unsigned(input int v, input int w);
        int max_v;
        max_v = (1 << w) - 1;
        if (v < 0) begin
            return 0;
        end
        if (v > max_v) begin
            return max_v;
        end
        return v;
    endfunction

endpackage

// File: rtl/sep_moving_avg.sv
// rtl/sep_moving_avg.sv - sample ring buffer, running sum, half-length delay tap and fill count
module sep_moving_avg
    import sep_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int AVG_LOG2 = 4
) (
    input  logic                         adc_clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic [DATA_W+AVG_LOG2-1:0]   sum,
    output logic [DATA_W-1:0]            x_dly,
    output logic                         v1,
    output logic                         full
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;

    logic [DATA_W-1:0]   sample_buf_q [N];
    logic [DATA_W-1:0]   sample_buf_d [N];
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d, tap_ptr;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [DATA_W-1:0]   x_dly_q, x_dly_d;
    logic [CNT_W-1:0]    fill_q, fill_d;
    logic                v1_q, v1_d;
    logic                accept;

    assign accept = in_valid & ~clear;

    always_comb begin
        sample_buf_d = sample_buf_q;
        wr_ptr_d     = wr_ptr_q;
        sum_d        = sum_q;
        x_dly_d      = x_dly_q;
        fill_d       = fill_q;
        v1_d         = accept;
        // Pointer arithmetic wraps modulo N by width.
        tap_ptr      = wr_ptr_q - AVG_LOG2'(N / 2);
        if (accept) begin
            x_dly_d                = sample_buf_q[tap_ptr];
            sum_d                  = sum_q + SUM_W'(in_data) - SUM_W'(sample_buf_q[wr_ptr_q]);
            sample_buf_d[wr_ptr_q] = in_data;
            wr_ptr_d               = wr_ptr_q + AVG_LOG2'(1);
            if (fill_q != CNT_W'(N)) begin
                fill_d = fill_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge adc_clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < N; i++) begin
                sample_buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            sum_q    <= '0;
            x_dly_q  <= '0;
            fill_q   <= '0;
            v1_q     <= 1'b0;
        end else begin
            sample_buf_q <= sample_buf_d;
            wr_ptr_q     <= wr_ptr_d;
            sum_q        <= sum_d;
            x_dly_q      <= x_dly_d;
            fill_q       <= fill_d;
            v1_q         <= v1_d;
        end
    end

    assign sum   = sum_q;
    assign x_dly = x_dly_q;
    assign v1    = v1_q;
    assign full  = (fill_q == CNT_W'(N));

endmodule

// File: rtl/param_signal_separation.sv
// rtl/param_signal_separation.sv - two-band ADC separator top; SEP_AMPL_EN adds high-band peak-to-peak tracker
module param_signal_separation
    import sep_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int AVG_LOG2 = 4
) (
    input  logic              adc_clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] low_out,
    output logic [DATA_W-1:0] high_out,
    output logic              out_valid,
    output logic              settled,
    output logic [DATA_W-1:0] hf_ampl,
    output logic              hf_ampl_valid
);

    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int HW    = DATA_W + 2;
    localparam logic [DATA_W-1:0] MID = DATA_W'(midscale(DATA_W));

    logic [SUM_W-1:0]     sum;
    logic [DATA_W-1:0]    x_dly, lo, hi;
    logic                 v1, full, stage2;
    logic signed [HW-1:0] hi_wide;

    sep_mode_e         mode1_q, mode1_d;
    logic [DATA_W-1:0] low_q, low_d, high_q, high_d;
    logic              out_valid_q, out_valid_d, settled_q, settled_d;

    sep_moving_avg #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .adc_clk  (adc_clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .sum      (sum),
        .x_dly    (x_dly),
        .v1       (v1),
        .full     (full)
    );

    // A clear in the same cycle drops the sample already in stage 2.
    assign stage2 = v1 & ~clear;
    assign lo     = sum[SUM_W-1:AVG_LOG2];

    always_comb begin
        mode1_d     = mode1_q;
        low_d       = low_q;
        high_d      = high_q;
        out_valid_d = stage2;
        settled_d   = clear ? 1'b0 : (settled_q | (stage2 & full));
        hi_wide     = $signed({2'b00, x_dly}) - $signed({2'b00, lo}) + $signed({2'b00, MID});
        hi          = DATA_W'(sat_unsigned(int'(hi_wide), DATA_W));
        if (in_valid && !clear) begin
            mode1_d = sep_mode_e'(mode);
        end
        if (stage2) begin
            case (mode1_q)
                SEP_MODE_LOWBYP: begin
                    low_d  = x_dly;
                    high_d = MID;
                end
                SEP_MODE_HIGHONLY: begin
                    low_d  = '0;
                    high_d = hi;
                end
                default: begin
                    low_d  = lo;
                    high_d = hi;
                end
            endcase
        end
    end

    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            mode1_q     <= SEP_MODE_SEPARATE;
            low_q       <= '0;
            high_q      <= MID;
            out_valid_q <= 1'b0;
            settled_q   <= 1'b0;
        end else begin
            mode1_q     <= mode1_d;
            low_q       <= low_d;
            high_q      <= high_d;
            out_valid_q <= out_valid_d;
            settled_q   <= settled_d;
        end
    end

    assign low_out   = low_q;
    assign high_out  = high_q;
    assign out_valid = out_valid_q;
    assign settled   = settled_q;

`ifdef SEP_AMPL_EN
    localparam int N = 1 << AVG_LOG2;

    logic [AVG_LOG2-1:0] blk_cnt_q, blk_cnt_d;
    logic [DATA_W-1:0]   min_q, min_d, max_q, max_d, ampl_q, ampl_d;
    logic                ampl_valid_q, ampl_valid_d;

    // Block boundaries follow processed samples, not the fill count.
    always_comb begin
        blk_cnt_d    = blk_cnt_q;
        min_d        = min_q;
        max_d        = max_q;
        ampl_d       = ampl_q;
        ampl_valid_d = 1'b0;
        if (clear) begin
            blk_cnt_d = '0;
        end else if (stage2) begin
            min_d     = (blk_cnt_q == '0 || hi < min_q) ? hi : min_q;
            max_d     = (blk_cnt_q == '0 || hi > max_q) ? hi : max_q;
            blk_cnt_d = blk_cnt_q + AVG_LOG2'(1);
            if (blk_cnt_q == AVG_LOG2'(N - 1)) begin
                ampl_d       = max_d - min_d;
                ampl_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge adc_clk) begin
        if (!rst_n) begin
            blk_cnt_q    <= '0;
            min_q        <= '0;
            max_q        <= '0;
            ampl_q       <= '0;
            ampl_valid_q <= 1'b0;
        end else begin
            blk_cnt_q    <= blk_cnt_d;
            min_q        <= min_d;
            max_q        <= max_d;
            ampl_q       <= ampl_d;
            ampl_valid_q <= ampl_valid_d;
        end
    end

    assign hf_ampl       = ampl_q;
    assign hf_ampl_valid = ampl_valid_q;
`else
    assign hf_ampl       = '0;
    assign hf_ampl_valid = 1'b0;
`endif

endmodule

// File: doc/param_signal_separation.md
Name: param_signal_separation

Overview:
Parametrised two-band separator for the ADC front end. It splits each accepted ADC sample into a low band and a high band. The low band is a 2^AVG_LOG2-tap moving average. The high band is the group-delay-aligned input minus the low band, re-biased to midscale. It sits directly after the ADC capture register in the adc_clk domain and feeds the downstream band processors. It adds a sample-valid handshake, runtime modes, a warm-up flag and a clear input.

Parameters:
DATA_W, 8, width of ADC samples and of both band outputs (unsigned, 4..16)
AVG_LOG2, 4, log2 of moving-average length N = 2^AVG_LOG2 (1..8); the delay tap is N/2

Ports:
adc_clk  in  1  sample clock; all logic on rising edge
rst_n  in  1  reset
in_valid  in  1  qualifies in_data; no backpressure
in_data  in  DATA_W  unsigned ADC sample
clear  in  1  synchronous flush of filter state (same effect as reset, outputs excluded)
mode  in  2  00 separate, 01 low-bypass, 10 high-only, 11 reserved (treated as 00)
low_out  out  DATA_W  low band, unsigned
high_out  out  DATA_W  high band, unsigned, midscale = 2^(DATA_W-1)
out_valid  out  1  one-cycle pulse per processed sample
settled  out  1  high once N samples accepted since reset/clear
hf_ampl  out  DATA_W  high-band peak-to-peak per block (optional feature)
hf_ampl_valid  out  1  one-cycle pulse on hf_ampl update (optional feature)

Behaviour:
- Reset: rst_n is synchronous, active-low; the clock is adc_clk.
  - Low (rst_n=0) at a rising edge clears: sample buffer (N registers), running sum, wr_ptr, fill count, pipeline regs.
  - Outputs after reset: low_out=0, high_out=midscale, out_valid=0, settled=0, hf_ampl=0, hf_ampl_valid=0.
- Stage 1, on a cycle with in_valid=1:
  - x_dly <= buf[(wr_ptr - N/2) mod N], read before the write.
  - sum <= sum + in_data - buf[wr_ptr]; the sum is DATA_W+AVG_LOG2 bits and cannot overflow.
  - buf[wr_ptr] <= in_data; wr_ptr increments and wraps N-1 -> 0.
  - fill count saturates at N.
  - Registers v1=1 and captures mode.
- Stage 2, on a cycle with v1=1:
  - lo = sum >> AVG_LOG2 (truncate).
  - hi = x_dly - lo + midscale, computed signed in DATA_W+2 bits, saturated to [0, 2^DATA_W-1].
  - mode 00: low_out=lo, high_out=hi.
  - mode 01: low_out=x_dly, high_out=midscale.
  - mode 10: low_out=0, high_out=hi.
  - out_valid=1 for that cycle.
- Latency: exactly 2 adc_clk cycles from the in_valid edge to the out_valid pulse.
- Outputs hold their value between pulses. Back-to-back in_valid gives back-to-back out_valid; the pipeline is fully throughput-1.
- Warm-up: the buffer starts at zeros, so early outputs are computed against zeros. settled goes high in the same cycle as the out_valid of the Nth sample and stays high until reset/clear.
- mode is sampled per sample in stage 1. A change affects only samples accepted after it; filter state updates in every mode.
- clear=1:
  - Behaves like reset on buffer, sum, wr_ptr, fill count, v1 and settled.
  - Leaves low_out/high_out holding their values; out_valid is forced 0 in the next cycle.
  - A sample presented in the same cycle as clear is discarded.
- Reset mid-stream: in-flight samples are dropped, with no out_valid for them.

Optional Feature:
- Macro SEP_AMPL_EN.
- Defined:
  - Tracks min and max of the stage-2 hi over blocks of N consecutive processed samples; the block boundary is fill-independent and counts from reset/clear.
  - On the last sample of each block: hf_ampl <= max-min, hf_ampl_valid pulses with that sample's out_valid, and the trackers restart from the next sample.
  - hi is tracked regardless of mode.
- Undefined: hf_ampl and hf_ampl_valid are tied to 0 and no tracker logic is generated.

Decomposition:
- Package sep_pkg:
  - mode encodings SEP_MODE_SEPARATE/LOWBYP/HIGHONLY
  - midscale constant function
  - saturation helper function
- Sub-module sep_moving_avg: buffer, running sum, wr_ptr, delay tap, fill count.
- The top adds the stage-2 band math, mode mux and the optional amplitude tracker.

Test Plan:
- Constant 100, DATA_W=8, AVG_LOG2=2:
  - Outputs in order: low 25/50/75/100, high 103/78/153/128.
  - settled rises with the 4th out_valid; thereafter low=100, high=128.
- Alternating 0/255, AVG_LOG2=2, settled: low=127 every sample; high alternates 255 (saturated, from 256) and 1.
- in_valid bursts with gaps: out_valid is exactly 2 cycles after each accepted sample, with no pulses otherwise; outputs hold during gaps.
- Mode switch 00->01 mid-stream at constant 100: the first sample after the switch gives low=x_dly=100, high=128; switching to 10 gives low=0.
- clear asserted with in_valid=1 mid-stream: that sample produces no output; the next sample yields low=x/4 (warm-up restart) and settled=0.
- SEP_AMPL_EN with alternating 0/255 after settle: hf_ampl=254 pulses every 4 samples; without the macro hf_ampl stays 0.
